subleq_control: RTL and testbench

- Sequencing controller for the subleq core.
- Drives the PC register's branch/inc/addr inputs and consumes the PC value.
- Runs the memory transactions of one subleq instruction: fetch A, B, C; read mem[A], mem[B]; write mem[B]-mem[A] to B; branch to C if the result is <= 0.
- Sits between the PC register and the unified word memory.

---
 rtl/subleq_control_pkg.sv | 19 +
 rtl/subleq_alu.sv | 17 +
 rtl/subleq_control.sv | 168 ++++++++++++++++
 tb/tb_subleq_control.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/subleq_control_pkg.sv
// Shared constants for the subleq sequencing controller: state encoding and
// default word width.
package subleq_control_pkg;

  localparam int WORD_SIZE_DEFAULT = 16;

  localparam logic [2:0] FETCH_A = 3'd0;
  localparam logic [2:0] FETCH_B = 3'd1;
  localparam logic [2:0] FETCH_C = 3'd2;
  localparam logic [2:0] READ_A  = 3'd3;
  localparam logic [2:0] READ_B  = 3'd4;
  localparam logic [2:0] WRITE_B = 3'd5;
  localparam logic [2:0] HALT    = 3'd6;

  function automatic logic is_fetch(input logic [2:0] s);
    return (s == FETCH_A) || (s == FETCH_B) || (s == FETCH_C);
  endfunction

endpackage

// File: rtl/subleq_alu.sv
// Subtract-and-test datapath: res = vb - va (wrapping), leq when res <= 0 as
// a signed value.
module subleq_alu
  import subleq_control_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEFAULT
) (
  input  logic [WORD_SIZE-1:0] va,
  input  logic [WORD_SIZE-1:0] vb,
  output logic [WORD_SIZE-1:0] res,
  output logic                 leq
);

  assign res = vb - va;
  assign leq = res[WORD_SIZE-1] | (res == '0);

endmodule

// File: rtl/subleq_control.sv
// Sequencer for one subleq instruction: three operand fetches, two data reads,
// one write-back and an optional branch, over a ready-handshaked memory.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   FETCH_A | fetch A word at pc_in (idle while run=0)
//   FETCH_B | fetch B word at pc_in
//   FETCH_C | fetch C word at pc_in
//   READ_A  | read mem[a_reg] into va
//   READ_B  | read mem[b_reg] into vb
//   WRITE_B | write vb-va to mem[b_reg], branch to C if <= 0
//   HALT    | self-loop detected, stopped until reset
module subleq_control
  import subleq_control_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 areset_n,
  input  logic                 run,
  input  logic [WORD_SIZE-1:0] pc_in,
  output logic                 branch,
  output logic                 inc,
  output logic [WORD_SIZE-1:0] addr,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ready,
  output logic                 halted
);

  logic [2:0]           state;
  logic [WORD_SIZE-1:0] a_reg;
  logic [WORD_SIZE-1:0] b_reg;
  logic [WORD_SIZE-1:0] c_reg;
  logic [WORD_SIZE-1:0] va;
  logic [WORD_SIZE-1:0] vb;
  logic [WORD_SIZE-1:0] insn_addr;
  logic                 fetch_busy;

  logic [WORD_SIZE-1:0] res;
  logic                 leq;

  logic                 req_i;
  logic                 we_i;
  logic [WORD_SIZE-1:0] addr_i;
  logic [WORD_SIZE-1:0] wdata_i;
  logic                 fire;
  logic                 self_loop;
  logic                 take_branch;

  subleq_alu #(.WORD_SIZE(WORD_SIZE)) u_alu (
    .va  (va),
    .vb  (vb),
    .res (res),
    .leq (leq)
  );

  // Once the A fetch is on the bus it stays there even if run drops,
  // so the request is never withdrawn before its ready cycle.
  always_comb begin
    req_i   = 1'b0;
    we_i    = 1'b0;
    addr_i  = '0;
    wdata_i = '0;
    case (state)
      FETCH_A: begin
        req_i  = run | fetch_busy;
        addr_i = req_i ? pc_in : '0;
      end
      FETCH_B, FETCH_C: begin
        req_i  = 1'b1;
        addr_i = pc_in;
      end
      READ_A: begin
        req_i  = 1'b1;
        addr_i = a_reg;
      end
      READ_B: begin
        req_i  = 1'b1;
        addr_i = b_reg;
      end
      WRITE_B: begin
        req_i   = 1'b1;
        we_i    = 1'b1;
        addr_i  = b_reg;
        wdata_i = res;
      end
      default: begin
        req_i = 1'b0;
      end
    endcase
  end

  assign fire        = req_i & mem_ready;
  assign self_loop   = (c_reg == insn_addr);
  assign take_branch = (state == WRITE_B) & fire & leq & ~self_loop;

  // Every output is forced low while reset is asserted, independent of state.
  assign mem_req   = areset_n & req_i;
  assign mem_we    = areset_n & we_i;
  assign mem_addr  = areset_n ? addr_i : '0;
  assign mem_wdata = areset_n ? wdata_i : '0;
  assign inc       = areset_n & fire & is_fetch(state);
  assign branch    = areset_n & take_branch;
  assign addr      = branch ? c_reg : '0;
  assign halted    = areset_n & (state == HALT);

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state      <= FETCH_A;
      a_reg      <= '0;
      b_reg      <= '0;
      c_reg      <= '0;
      va         <= '0;
      vb         <= '0;
      insn_addr  <= '0;
      fetch_busy <= 1'b0;
    end else begin
      case (state)
        FETCH_A: begin
          fetch_busy <= req_i & ~mem_ready;
          if (req_i) insn_addr <= pc_in;
          if (fire) begin
            a_reg <= mem_rdata;
            state <= FETCH_B;
          end
        end
        FETCH_B: begin
          if (fire) begin
            b_reg <= mem_rdata;
            state <= FETCH_C;
          end
        end
        FETCH_C: begin
          if (fire) begin
            c_reg <= mem_rdata;
            state <= READ_A;
          end
        end
        READ_A: begin
          if (fire) begin
            va    <= mem_rdata;
            state <= READ_B;
          end
        end
        READ_B: begin
          if (fire) begin
            vb    <= mem_rdata;
            state <= WRITE_B;
          end
        end
        WRITE_B: begin
          if (fire) state <= (leq && self_loop) ? HALT : FETCH_A;
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= FETCH_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subleq_control.sv
// Bench for subleq_control: word memory with programmable wait states, a PC
// register model, and a transaction scoreboard.
module tb_subleq_control;

  typedef struct packed {
    logic        we;
    logic [15:0] a;
    logic [15:0] d;
  } txn_t;

  logic        clk = 1'b0;
  logic        areset_n = 1'b0;
  logic        run = 1'b0;
  logic [15:0] pc;
  logic        branch, inc, mem_req, mem_we, halted;
  logic [15:0] addr, mem_addr, mem_wdata;
  logic [15:0] mem_rdata = 16'h0;
  logic        mem_ready = 1'b0;

  logic [15:0] mem [0:255];
  int          stall = 0;
  logic        ready_junk = 1'b0;
  int          cnt = 0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_load_val = 16'h0;
  int          cyc = 0;

  int checks = 0;
  int errors = 0;

  txn_t        obs_q[$];
  txn_t        exp_q[$];
  int          obs_cyc[$];
  logic [15:0] br_q[$];
  int          inc_cnt = 0, req_cnt = 0, stab_err = 0, both_err = 0, inc_err = 0;
  logic        prev_pend = 1'b0;
  txn_t        prev_t;

  always #5 clk = ~clk;

  subleq_control #(.WORD_SIZE(16)) dut (
    .clk       (clk),
    .areset_n  (areset_n),
    .run       (run),
    .pc_in     (pc),
    .branch    (branch),
    .inc       (inc),
    .addr      (addr),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .halted    (halted)
  );

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (pc_load) pc <= pc_load_val;
    else if (branch) pc <= addr;
    else if (inc) pc <= pc + 16'd1;
  end

  always @(posedge clk) begin
    if (mem_req && mem_ready && mem_we) mem[mem_addr[7:0]] = mem_wdata;
  end

  // Memory responder: 'stall' not-ready cycles before each acknowledge.
  always @(negedge clk) begin
    if (!mem_req) begin
      mem_ready = ready_junk;
      cnt = 0;
    end else begin
      if (mem_ready) cnt = 0;
      if (cnt >= stall) begin
        mem_ready = 1'b1;
        mem_rdata = mem[mem_addr[7:0]];
      end else begin
        mem_ready = 1'b0;
        cnt++;
      end
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (mem_req) req_cnt++;
    if (inc) begin
      inc_cnt++;
      if (!mem_ready) inc_err++;
    end
    if (branch) br_q.push_back(addr);
    if (inc && branch) both_err++;
    if (prev_pend && mem_req && (prev_t != {mem_we, mem_addr, mem_wdata})) stab_err++;
    if (mem_req && mem_ready) begin
      obs_q.push_back({mem_we, mem_addr, mem_wdata});
      obs_cyc.push_back(cyc);
    end
    prev_pend = mem_req && !mem_ready;
    prev_t    = {mem_we, mem_addr, mem_wdata};
  end

  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  task automatic start_reset(input logic [15:0] pc0);
    areset_n = 1'b0;
    run = 1'b0;
    stall = 0;
    ready_junk = 1'b0;
    pc_load = 1'b1;
    pc_load_val = pc0;
    tick();
    pc_load = 1'b0;
    tick();
    obs_q.delete();
    exp_q.delete();
    obs_cyc.delete();
    br_q.delete();
    inc_cnt = 0;
    stab_err = 0;
    both_err = 0;
    inc_err = 0;
  endtask

  task automatic test_reset();
    areset_n = 1'b0;
    run = 1'b1;
    pc_load = 1'b1;
    pc_load_val = 16'h0005;
    tick();
    pc_load = 1'b0;
    tick();
    checks++;
    if ({mem_req, mem_we, inc, branch, halted} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000", {mem_req, mem_we, inc, branch, halted});
    end
    checks++;
    if ({mem_addr, mem_wdata, addr} !== 48'h0) begin
      errors++;
      $display("FAIL reset_buses: got %h expected 0", {mem_addr, mem_wdata, addr});
    end
  endtask

  task automatic test_run_low();
    int r0;
    start_reset(16'h0);
    ready_junk = 1'b1;
    areset_n = 1'b1;
    r0 = req_cnt;
    repeat (10) tick();
    checks++;
    if (req_cnt !== r0 || obs_q.size() != 0 || inc_cnt != 0) begin
      errors++;
      $display("FAIL run_low_idle: got req=%0d txns=%0d inc=%0d expected 0 0 0",
               req_cnt - r0, obs_q.size(), inc_cnt);
    end
    ready_junk = 1'b0;
  endtask

  task automatic exec_one(input string name, input logic [15:0] pc0, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] c, input logic [15:0] va_v,
                          input logic [15:0] vb_v, input int st, input logic keep_run);
    logic [15:0] res, pc_e;
    logic        leq, halt_e, br_e;
    int          budget, r0;
    txn_t        o, e;
    start_reset(pc0);
    stall = st;
    mem[8'(pc0)] = a;
    mem[8'(pc0 + 16'd1)] = b;
    mem[8'(pc0 + 16'd2)] = c;
    mem[a[7:0]] = va_v;
    mem[b[7:0]] = vb_v;
    res    = vb_v - va_v;
    leq    = res[15] | (res == 16'h0);
    halt_e = leq && (c == pc0);
    br_e   = leq && !halt_e;
    pc_e   = br_e ? c : pc0 + 16'd3;
    exp_q.push_back({1'b0, pc0, 16'h0});
    exp_q.push_back({1'b0, pc0 + 16'd1, 16'h0});
    exp_q.push_back({1'b0, pc0 + 16'd2, 16'h0});
    exp_q.push_back({1'b0, a, 16'h0});
    exp_q.push_back({1'b0, b, 16'h0});
    exp_q.push_back({1'b1, b, res});
    areset_n = 1'b1;
    run = 1'b1;
    budget = 400;
    while (obs_q.size() < 3 && budget > 0) begin tick(); budget--; end
    tick();
    if (!keep_run) run = 1'b0;
    while (obs_q.size() < 6 && budget > 0) begin tick(); budget--; end
    checks++;
    if (budget == 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d txns expected 6", name, obs_q.size());
    end
    tick();
    checks++;
    if (halted !== halt_e) begin
      errors++;
      $display("FAIL %s_halted: got %b expected %b", name, halted, halt_e);
    end
    tick();
    tick();
    checks++;
    if (obs_q.size() != 6) begin
      errors++;
      $display("FAIL %s_txn_count: got %0d expected 6", name, obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s_txn: got we=%b a=%h d=%h expected we=%b a=%h d=%h",
                 name, o.we, o.a, o.d, e.we, e.a, e.d);
      end
    end
    checks++;
    if (inc_cnt != 3) begin
      errors++;
      $display("FAIL %s_inc_count: got %0d expected 3", name, inc_cnt);
    end
    checks++;
    if (br_q.size() != (br_e ? 1 : 0) || (br_e && br_q.size() > 0 && br_q[0] !== c)) begin
      errors++;
      $display("FAIL %s_branch: got %0d pulses expected %0d to %h", name, br_q.size(), br_e, c);
    end
    checks++;
    if (pc !== pc_e) begin
      errors++;
      $display("FAIL %s_pc: got %h expected %h", name, pc, pc_e);
    end
    checks++;
    if (mem[b[7:0]] !== res) begin
      errors++;
      $display("FAIL %s_mem_b: got %h expected %h", name, mem[b[7:0]], res);
    end
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_req: got %b expected 0", name, mem_req);
    end
    checks++;
    if (obs_cyc.size() >= 6 && (obs_cyc[5] - obs_cyc[0]) != 5 * (st + 1)) begin
      errors++;
      $display("FAIL %s_cycles: got %0d expected %0d", name, obs_cyc[5] - obs_cyc[0], 5 * (st + 1));
    end
    checks++;
    if (stab_err != 0 || both_err != 0 || inc_err != 0) begin
      errors++;
      $display("FAIL %s_protocol: got stab=%0d both=%0d inc_nr=%0d expected 0 0 0",
               name, stab_err, both_err, inc_err);
    end
    if (halt_e) begin
      r0 = req_cnt;
      repeat (20) tick();
      checks++;
      if (req_cnt != r0 || halted !== 1'b1 || br_q.size() != 0) begin
        errors++;
        $display("FAIL %s_halt_hold: got req=%0d halted=%b br=%0d expected 0 1 0",
                 name, req_cnt - r0, halted, br_q.size());
      end
    end else begin
      run = 1'b1;
      tick();
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== pc_e) begin
        errors++;
        $display("FAIL %s_next_fetch: got req=%b addr=%h expected 1 %h", name, mem_req, mem_addr, pc_e);
      end
      run = 1'b0;
    end
  endtask

  task automatic test_reset_write();
    int   budget;
    txn_t o, e;
    start_reset(16'h0);
    stall = 3;
    mem[0] = 16'd3; mem[1] = 16'd4; mem[2] = 16'd9; mem[3] = 16'd5; mem[4] = 16'd2;
    areset_n = 1'b1;
    run = 1'b1;
    budget = 200;
    while (!(mem_req && mem_we && !mem_ready) && budget > 0) begin tick(); budget--; end
    checks++;
    if (budget == 0) begin
      errors++;
      $display("FAIL rst_wr_timeout: got no write request expected one");
    end
    areset_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_we, branch, inc} !== 4'b0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
      errors++;
      $display("FAIL rst_wr_outputs: got req=%b we=%b addr=%h wd=%h expected 0 0 0000 0000",
               mem_req, mem_we, mem_addr, mem_wdata);
    end
    repeat (3) tick();
    checks++;
    if (mem[4] !== 16'd2 || obs_q.size() != 5 || br_q.size() != 0) begin
      errors++;
      $display("FAIL rst_wr_abandon: got mem4=%h txns=%0d br=%0d expected 0002 5 0",
               mem[4], obs_q.size(), br_q.size());
    end
    exp_q.push_back({1'b0, 16'd3, 16'h0});
    void'(obs_q.pop_front()); void'(obs_q.pop_front()); void'(obs_q.pop_front());
    void'(obs_q.pop_front()); void'(obs_q.pop_front());
    areset_n = 1'b1;
    budget = 100;
    while (obs_q.size() < 1 && budget > 0) begin tick(); budget--; end
    checks++;
    if (obs_q.size() < 1) begin
      errors++;
      $display("FAIL rst_wr_refetch: got no fetch expected fetch at 0003");
    end else begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rst_wr_refetch_addr: got we=%b a=%h expected we=%b a=%h", o.we, o.a, e.we, e.a);
      end
    end
    run = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    test_reset();
    test_run_low();
    exec_one("branch",   16'd0, 16'd3,  16'd4,  16'd9,  16'd5, 16'd2,     0, 1'b0);
    exec_one("nobranch", 16'd0, 16'd3,  16'd4,  16'd9,  16'd2, 16'd5,     0, 1'b0);
    exec_one("equal",    16'd0, 16'd3,  16'd4,  16'd12, 16'd7, 16'd7,     0, 1'b0);
    exec_one("wrap",     16'd0, 16'd3,  16'd4,  16'd12, 16'd1, 16'h8000,  0, 1'b0);
    exec_one("alias",    16'd0, 16'd3,  16'd3,  16'd14, 16'd7, 16'd7,     0, 1'b0);
    exec_one("halt",     16'd6, 16'd10, 16'd11, 16'd6,  16'd9, 16'd4,     0, 1'b1);
    exec_one("stall",    16'd0, 16'd3,  16'd4,  16'd9,  16'd5, 16'd2,     3, 1'b0);
    test_reset_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
